// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM state codes and the select codes driven onto the datapath muxes.
package mips_pkg;

  localparam int ST_BITS = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [ST_BITS-1:0] S_FETCH   = 4'd0;
  localparam logic [ST_BITS-1:0] S_DECODE  = 4'd1;
  localparam logic [ST_BITS-1:0] S_MEM_ADR = 4'd2;
  localparam logic [ST_BITS-1:0] S_MEM_RD  = 4'd3;
  localparam logic [ST_BITS-1:0] S_MEM_WB  = 4'd4;
  localparam logic [ST_BITS-1:0] S_MEM_WR  = 4'd5;
  localparam logic [ST_BITS-1:0] S_EXE_R   = 4'd6;
  localparam logic [ST_BITS-1:0] S_RWB     = 4'd7;
  localparam logic [ST_BITS-1:0] S_EXE_I   = 4'd8;
  localparam logic [ST_BITS-1:0] S_IWB     = 4'd9;
  localparam logic [ST_BITS-1:0] S_BRANCH  = 4'd10;
  localparam logic [ST_BITS-1:0] S_JUMP    = 4'd11;
  localparam logic [ST_BITS-1:0] S_JR      = 4'd12;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;
  localparam logic [1:0] PCSRC_RS  = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL = 2'd3;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_SLT   = 3'd3;
  localparam logic [2:0] ALU_LUI   = 3'd4;
  localparam logic [2:0] ALU_FUNCT = 3'd5;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/mc_dispatch.sv
// DECODE-state dispatch: maps the instruction's opcode/funct to the first
// execution state, flagging anything the core does not implement.
module mc_dispatch
  import mips_pkg::*;
(
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [ST_BITS-1:0] next_state,
  output logic               illegal
);

  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR:                     next_state = S_JR;
          FN_ADDU, FN_SUBU, FN_SLT:  next_state = S_EXE_R;
          default:                   illegal    = 1'b1;
        endcase
      end
      OP_LW, OP_SW:             next_state = S_MEM_ADR;
      OP_ADDIU, OP_ORI, OP_LUI: next_state = S_EXE_I;
      OP_BEQ, OP_BNE:           next_state = S_BRANCH;
      OP_J, OP_JAL:             next_state = S_JUMP;
      default:                  illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/write-back
// and decodes datapath enables and mux selects from the current state.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            iord,
  output logic            mem_req,
  output logic            mem_we,
  output logic            ir_write,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      wb_sel,
  output logic            alusrc_a,
  output logic [1:0]      alusrc_b,
  output logic [2:0]      alu_op,
  output logic            ext_op,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  logic [ST_BITS-1:0] r_state;
  logic [ST_BITS-1:0] w_next;
  logic [ST_BITS-1:0] w_disp_state;
  logic               w_disp_illegal;

  mc_dispatch u_dispatch (
    .opcode     (opcode),
    .funct      (funct),
    .next_state (w_disp_state),
    .illegal    (w_disp_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  assign state = ST_W'(r_state);

  // All strobes are forced low while rst is high, whatever state we are in.
  always_comb begin
    w_next    = r_state;
    pc_write  = 1'b0;
    pc_src    = PCSRC_SEQ;
    iord      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = RDST_RT;
    wb_sel    = WB_ALU;
    alusrc_a  = 1'b0;
    alusrc_b  = SRCB_RT;
    alu_op    = ALU_ADD;
    ext_op    = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          alusrc_b = SRCB_4;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          alusrc_b = SRCB_IMM_SL;
          ext_op   = 1'b1;
          illegal  = w_disp_illegal;
          w_next   = w_disp_state;
        end
        S_MEM_ADR: begin
          alusrc_a = 1'b1;
          alusrc_b = SRCB_IMM;
          ext_op   = 1'b1;
          w_next   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) w_next = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
          w_next    = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) w_next = S_FETCH;
        end
        S_EXE_R: begin
          alusrc_a = 1'b1;
          alu_op   = ALU_FUNCT;
          w_next   = S_RWB;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = RDST_RD;
          w_next    = S_FETCH;
        end
        S_EXE_I: begin
          alusrc_a = 1'b1;
          alusrc_b = SRCB_IMM;
          case (opcode)
            OP_ORI:  alu_op = ALU_OR;
            OP_LUI:  alu_op = ALU_LUI;
            default: ext_op = 1'b1;
          endcase
          w_next = S_IWB;
        end
        S_IWB: begin
          reg_write = 1'b1;
          w_next    = S_FETCH;
        end
        S_BRANCH: begin
          alusrc_a = 1'b1;
          alu_op   = ALU_SUB;
          pc_src   = PCSRC_BR;
          pc_write = (opcode == OP_BNE) ? ~zero : zero;
          w_next   = S_FETCH;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JMP;
          if (opcode == OP_JAL) begin
            reg_write = 1'b1;
            reg_dst   = RDST_RA;
            wb_sel    = WB_PC;
          end
          w_next = S_FETCH;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_RS;
          w_next   = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboarded bench for mc_ctrl: an instruction-level model pushes the
// expected per-cycle control word, a negedge monitor pops and compares.
module tb_mc_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, iord, mem_req, mem_we, ir_write, reg_write;
  logic       alusrc_a, ext_op, illegal;
  logic [1:0] pc_src, reg_dst, wb_sel, alusrc_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  mc_ctrl #(.ST_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .alu_op(alu_op),
    .ext_op(ext_op), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       req;
    logic       we;
    logic       irw;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] wb;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       ext;
    logic       ill;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e, mon_a;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  always @(negedge clk) begin
    cyc_no++;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      mon_a = {state, pc_write, pc_src, iord, mem_req, mem_we, ir_write,
               reg_write, reg_dst, wb_sel, alusrc_a, alusrc_b, alu_op,
               ext_op, illegal};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL ctrl_word cycle %0d: got st=%0d word=%h, want st=%0d word=%h",
                 cyc_no, mon_a.st, mon_a, mon_e.st, mon_e);
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic supported(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0D,
                      6'h0F, 6'h23, 6'h2B};
  endfunction

  task automatic cyc(input exp_t e, input logic rdy, input logic z, input logic r);
    rst = r;
    mem_ready = rdy;
    zero = z;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_phase(input int fst);
    exp_t e;
    for (int i = 0; i < fst; i++) begin
      e = mk(S_FETCH); e.req = 1'b1; e.asb = 2'd1;
      cyc(e, 1'b0, rb(), 1'b0);
    end
    e = mk(S_FETCH); e.req = 1'b1; e.asb = 2'd1; e.irw = 1'b1; e.pcw = 1'b1;
    cyc(e, 1'b1, rb(), 1'b0);
  endtask

  // One whole instruction, sequenced from its class and the stall counts.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int fst, input int mst);
    exp_t e;
    logic is_r, is_jr, bad;
    is_r  = (op == 6'h00) && (fn inside {6'h21, 6'h23, 6'h2A});
    is_jr = (op == 6'h00) && (fn == 6'h08);
    bad   = !supported(op) || ((op == 6'h00) && !is_r && !is_jr);
    opcode = op;
    funct  = fn;
    fetch_phase(fst);
    e = mk(S_DECODE); e.asb = 2'd3; e.ext = 1'b1; e.ill = bad;
    cyc(e, rb(), rb(), 1'b0);
    if (bad) return;
    if (op == 6'h23 || op == 6'h2B) begin
      e = mk(S_MEM_ADR); e.asa = 1'b1; e.asb = 2'd2; e.ext = 1'b1;
      cyc(e, rb(), rb(), 1'b0);
      for (int i = 0; i <= mst; i++) begin
        if (op == 6'h23) begin
          e = mk(S_MEM_RD); e.req = 1'b1; e.iord = 1'b1;
        end else begin
          e = mk(S_MEM_WR); e.req = 1'b1; e.iord = 1'b1; e.we = 1'b1;
        end
        cyc(e, (i == mst), rb(), 1'b0);
      end
      if (op == 6'h23) begin
        e = mk(S_MEM_WB); e.rw = 1'b1; e.wb = 2'd1;
        cyc(e, rb(), rb(), 1'b0);
      end
    end else if (is_r) begin
      e = mk(S_EXE_R); e.asa = 1'b1; e.aop = 3'd5;
      cyc(e, rb(), rb(), 1'b0);
      e = mk(S_RWB); e.rw = 1'b1; e.rdst = 2'd1;
      cyc(e, rb(), rb(), 1'b0);
    end else if (is_jr) begin
      e = mk(S_JR); e.pcw = 1'b1; e.pcs = 2'd3;
      cyc(e, rb(), rb(), 1'b0);
    end else if (op == 6'h09 || op == 6'h0D || op == 6'h0F) begin
      e = mk(S_EXE_I); e.asa = 1'b1; e.asb = 2'd2;
      e.aop = (op == 6'h09) ? 3'd0 : (op == 6'h0D) ? 3'd2 : 3'd4;
      e.ext = (op == 6'h09);
      cyc(e, rb(), rb(), 1'b0);
      e = mk(S_IWB); e.rw = 1'b1;
      cyc(e, rb(), rb(), 1'b0);
    end else if (op == 6'h04 || op == 6'h05) begin
      e = mk(S_BRANCH); e.asa = 1'b1; e.aop = 3'd1; e.pcs = 2'd1;
      e.pcw = (op == 6'h04) ? z : !z;
      cyc(e, rb(), z, 1'b0);
    end else begin
      e = mk(S_JUMP); e.pcw = 1'b1; e.pcs = 2'd2;
      if (op == 6'h03) begin
        e.rw = 1'b1; e.rdst = 2'd2; e.wb = 2'd2;
      end
      cyc(e, rb(), rb(), 1'b0);
    end
  endtask

  task automatic sw_reset_in_stall();
    exp_t e;
    opcode = 6'h2B;
    funct  = 6'h00;
    fetch_phase(0);
    e = mk(S_DECODE); e.asb = 2'd3; e.ext = 1'b1;
    cyc(e, 1'b1, 1'b0, 1'b0);
    e = mk(S_MEM_ADR); e.asa = 1'b1; e.asb = 2'd2; e.ext = 1'b1;
    cyc(e, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = mk(S_MEM_WR); e.req = 1'b1; e.iord = 1'b1; e.we = 1'b1;
      cyc(e, 1'b0, 1'b0, 1'b0);
    end
    e = mk(S_MEM_WR);
    cyc(e, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [5:0] op, fn;
    int k;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(mk(S_FETCH), 1'b1, 1'b0, 1'b1);

    do_instr(6'h23, 6'h00, 1'b0, 0, 0);
    do_instr(6'h00, 6'h21, 1'b0, 3, 0);
    do_instr(6'h04, 6'h00, 1'b1, 0, 0);
    do_instr(6'h04, 6'h00, 1'b0, 0, 0);
    do_instr(6'h05, 6'h00, 1'b0, 0, 0);
    do_instr(6'h05, 6'h00, 1'b1, 0, 0);
    do_instr(6'h03, 6'h00, 1'b0, 0, 0);
    do_instr(6'h02, 6'h00, 1'b0, 0, 0);
    do_instr(6'h00, 6'h08, 1'b0, 0, 0);
    do_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    do_instr(6'h00, 6'h3F, 1'b0, 1, 0);
    do_instr(6'h2B, 6'h00, 1'b0, 0, 2);
    do_instr(6'h0F, 6'h00, 1'b0, 0, 0);
    sw_reset_in_stall();
    do_instr(6'h0D, 6'h00, 1'b0, 2, 0);

    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 14);
      fn = 6'($urandom);
      case (k)
        0:  begin op = 6'h00; fn = 6'h21; end
        1:  begin op = 6'h00; fn = 6'h23; end
        2:  begin op = 6'h00; fn = 6'h2A; end
        3:  begin op = 6'h00; fn = 6'h08; end
        4:  op = 6'h23;
        5:  op = 6'h2B;
        6:  op = 6'h04;
        7:  op = 6'h05;
        8:  op = 6'h09;
        9:  op = 6'h0D;
        10: op = 6'h0F;
        11: op = 6'h02;
        12: op = 6'h03;
        13: begin
          op = 6'($urandom);
          while (supported(op)) op = 6'($urandom);
        end
        default: begin
          op = 6'h00;
          while (fn inside {6'h08, 6'h21, 6'h23, 6'h2A}) fn = 6'($urandom);
        end
      endcase
      do_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
